// File: rtl/pc_pkg.sv
// Shared defaults and next-PC select encoding for the fetch-address generator.
package pc_pkg;
  localparam int          PC_XLEN_DEF      = 32;
  localparam int unsigned PC_INC_DEF       = 4;
  localparam int unsigned PC_RESET_VEC_DEF = 0;
  localparam int          RAS_DEPTH_DEF    = 4;

  typedef enum logic [1:0] {
    SEL_SEQ   = 2'd0,
    SEL_REDIR = 2'd1,
    SEL_RAS   = 2'd2,
    SEL_PEND  = 2'd3
  } pc_sel_e;
endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: push/pop pointer, saturating count, registered ovf/unf pulses.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] link_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            ovf_o,
  output logic            unf_o
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][XLEN-1:0] ent;
  logic [PW-1:0]                  ptr, ptr_m1;
  logic [PW:0]                    cnt;

  assign ptr_m1  = ptr - 1'b1;
  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == CNT_MAX);
  assign top_o   = empty_o ? '0 : ent[ptr_m1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ent   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else if (clr_i) begin
      ent   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      ovf_o <= push_i && !pop_i && full_o;
      unf_o <= pop_i && empty_o;
      if (push_i && pop_i && !empty_o) begin
        // call+return in one cycle: swap the top in place, depth unchanged
        ent[ptr_m1] <= link_i;
      end else if (push_i) begin
        ent[ptr] <= link_i;
        ptr      <= ptr + 1'b1;
        if (!full_o) cnt <= cnt + 1'b1;
      end else if (pop_i && !empty_o) begin
        ptr <= ptr_m1;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential/redirect/return/pending next-PC mux with stall-safe pending latch.
module pc_gen
  import pc_pkg::*;
#(
  parameter int          XLEN      = PC_XLEN_DEF,
  parameter int unsigned RESET_VEC = PC_RESET_VEC_DEF,
  parameter int unsigned INC       = PC_INC_DEF,
  parameter int          RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            call_i,
  input  logic [XLEN-1:0] link_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] ras_top_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_ovf_o,
  output logic            ras_unf_o
);
  logic            pend_vld;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] pc_nxt;
  logic            ras_hit;
  pc_sel_e         sel;

  ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (!start_i),
    .push_i  (call_i),
    .pop_i   (ret_i),
    .link_i  (link_i),
    .top_o   (ras_top_o),
    .empty_o (ras_empty_o),
    .full_o  (ras_full_o),
    .ovf_o   (ras_ovf_o),
    .unf_o   (ras_unf_o)
  );

  assign ras_hit = ret_i && !ras_empty_o;

  always_comb begin
    sel = SEL_SEQ;
    if (redirect_i)    sel = SEL_REDIR;
    else if (ras_hit)  sel = SEL_RAS;
    else if (pend_vld) sel = SEL_PEND;
    case (sel)
      SEL_REDIR: pc_nxt = redirect_pc_i;
      SEL_RAS:   pc_nxt = ras_top_o;
      SEL_PEND:  pc_nxt = pend_pc;
      default:   pc_nxt = pc_o + XLEN'(INC);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_o     <= XLEN'(RESET_VEC);
      pend_vld <= 1'b0;
      pend_pc  <= '0;
    end else if (!start_i) begin
      pc_o     <= XLEN'(RESET_VEC);
      pend_vld <= 1'b0;
      pend_pc  <= '0;
    end else if (stall_i) begin
      // hold the PC but remember the newest control-flow change for after the stall
      if (redirect_i) begin
        pend_pc  <= redirect_pc_i;
        pend_vld <= 1'b1;
      end else if (ras_hit) begin
        pend_pc  <= ras_top_o;
        pend_vld <= 1'b1;
      end
    end else begin
      pc_o     <= pc_nxt;
      pend_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (XLEN=32, RESET_VEC=0, INC=4, RAS_DEPTH=4).
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stall = 1'b0, redirect = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] redirect_pc = '0, link = '0;
  logic [31:0] pc, ras_top;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;
  int          n_cmp = 0, n_err = 0;

  pc_gen #(.XLEN(32), .RESET_VEC(0), .INC(4), .RAS_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .call_i(call), .link_i(link), .ret_i(ret),
    .pc_o(pc), .ras_top_o(ras_top), .ras_empty_o(ras_empty), .ras_full_o(ras_full),
    .ras_ovf_o(ras_ovf), .ras_unf_o(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    n_cmp++; if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin n_err++; $display("FAIL reset_ras got empty=%b top=%h exp empty=1 top=0", ras_empty, ras_top); end
    tick;
    rst_n = 1'b1;
    tick;
    start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick;
      n_cmp++; if (pc !== 32'(4*i)) begin n_err++; $display("FAIL seq_%0d got=%h exp=%h", i, pc, 32'(4*i)); end
    end
  endtask

  task automatic test_redirect;
    redirect = 1'b1; redirect_pc = 32'h200;
    tick;
    n_cmp++; if (pc !== 32'h200) begin n_err++; $display("FAIL redir got=%h exp=%h", pc, 32'h200); end
    redirect = 1'b0;
    tick;
    n_cmp++; if (pc !== 32'h204) begin n_err++; $display("FAIL redir_seq got=%h exp=%h", pc, 32'h204); end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect = 1'b0;
    tick;
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap got=%h exp=%h", pc, 32'h0); end
  endtask

  task automatic test_stall;
    redirect = 1'b1; redirect_pc = 32'h40;
    tick;
    stall = 1'b1; redirect_pc = 32'h300;
    tick;
    n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL stall1 got=%h exp=%h", pc, 32'h40); end
    redirect_pc = 32'h400;
    tick;
    n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL stall2 got=%h exp=%h", pc, 32'h40); end
    redirect = 1'b0;
    tick;
    n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL stall3 got=%h exp=%h", pc, 32'h40); end
    stall = 1'b0;
    tick;
    n_cmp++; if (pc !== 32'h400) begin n_err++; $display("FAIL pend_use got=%h exp=%h", pc, 32'h400); end
    tick;
    n_cmp++; if (pc !== 32'h404) begin n_err++; $display("FAIL pend_clr got=%h exp=%h", pc, 32'h404); end
  endtask

  task automatic test_ras_basic;
    call = 1'b1; link = 32'h104;
    tick;
    link = 32'h208;
    tick;
    call = 1'b0;
    n_cmp++; if (ras_top !== 32'h208 || pc !== 32'h40C) begin n_err++; $display("FAIL ras_push got top=%h pc=%h exp top=208 pc=40c", ras_top, pc); end
    ret = 1'b1;
    tick;
    n_cmp++; if (pc !== 32'h208) begin n_err++; $display("FAIL ret1 got=%h exp=%h", pc, 32'h208); end
    tick;
    ret = 1'b0;
    n_cmp++; if (pc !== 32'h104) begin n_err++; $display("FAIL ret2 got=%h exp=%h", pc, 32'h104); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ras_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_ras_overflow;
    logic [31:0] pushv [5] = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
    logic [31:0] popv  [4] = '{32'hE0, 32'hD0, 32'hC0, 32'hB0};
    call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      link = pushv[i];
      tick;
      if (i == 3) begin
        n_cmp++; if (ras_full !== 1'b1 || ras_ovf !== 1'b0) begin n_err++; $display("FAIL full4 got full=%b ovf=%b exp full=1 ovf=0", ras_full, ras_ovf); end
      end
    end
    call = 1'b0;
    n_cmp++; if (ras_ovf !== 1'b1 || ras_top !== 32'hE0) begin n_err++; $display("FAIL ovf got ovf=%b top=%h exp ovf=1 top=e0", ras_ovf, ras_top); end
    ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_cmp++; if (pc !== popv[i]) begin n_err++; $display("FAIL pop%0d got=%h exp=%h", i, pc, popv[i]); end
      if (i == 0) begin
        n_cmp++; if (ras_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_pulse got=%b exp=0", ras_ovf); end
      end
    end
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty got=%b exp=1", ras_empty); end
    tick;
    ret = 1'b0;
    n_cmp++; if (pc !== 32'hB4 || ras_unf !== 1'b1) begin n_err++; $display("FAIL unf got pc=%h unf=%b exp pc=b4 unf=1", pc, ras_unf); end
    tick;
    n_cmp++; if (pc !== 32'hB8 || ras_unf !== 1'b0) begin n_err++; $display("FAIL unf_pulse got pc=%h unf=%b exp pc=b8 unf=0", pc, ras_unf); end
  endtask

  task automatic test_back_to_back;
    call = 1'b1; link = 32'h500;
    tick;
    link = 32'h600;
    tick;
    call = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h700; ret = 1'b1;
    tick;
    redirect = 1'b0;
    n_cmp++; if (pc !== 32'h700 || ras_top !== 32'h500) begin n_err++; $display("FAIL redir_ret got pc=%h top=%h exp pc=700 top=500", pc, ras_top); end
    call = 1'b1; link = 32'h800;
    tick;
    call = 1'b0; ret = 1'b0;
    n_cmp++; if (pc !== 32'h500 || ras_top !== 32'h800 || ras_empty !== 1'b0) begin n_err++; $display("FAIL call_ret got pc=%h top=%h empty=%b exp pc=500 top=800 empty=0", pc, ras_top, ras_empty); end
    ret = 1'b1;
    tick;
    ret = 1'b0;
    n_cmp++; if (pc !== 32'h800 || ras_empty !== 1'b1) begin n_err++; $display("FAIL call_ret_depth got pc=%h empty=%b exp pc=800 empty=1", pc, ras_empty); end
  endtask

  task automatic test_async_reset;
    call = 1'b1; link = 32'h111;
    tick;
    link = 32'h222;
    tick;
    call = 1'b0;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h333;
    tick;
    redirect = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL async_pc got=%h exp=%h", pc, 32'h0); end
    n_cmp++; if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin n_err++; $display("FAIL async_ras got empty=%b top=%h exp empty=1 top=0", ras_empty, ras_top); end
    stall = 1'b0; start = 1'b0;
    tick;
    rst_n = 1'b1;
    call = 1'b1; link = 32'h999; redirect = 1'b1; redirect_pc = 32'h555;
    tick;
    tick;
    n_cmp++; if (pc !== 32'h0 || ras_empty !== 1'b1) begin n_err++; $display("FAIL start_gate got pc=%h empty=%b exp pc=0 empty=1", pc, ras_empty); end
    call = 1'b0; redirect = 1'b0;
    start = 1'b1;
    tick;
    n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL restart got=%h exp=%h", pc, 32'h4); end
  endtask

  initial begin
    test_reset;
    test_redirect;
    test_stall;
    test_ras_basic;
    test_ras_overflow;
    test_back_to_back;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
